max_pool_ctrl: RTL and testbench

Sequencing controller for the 2x2 max-pooling stage of the YOLOv3-tiny pipeline. It receives horizontally-pooled rows, one per handshake, from the `PE_MAX_POOL_array` lane array; lane i already holds max(col i, col i+1). It performs the vertical (row-to-row) max using a one-row hold register. It emits pooled rows with a lane-valid mask for stride 2 (layers 1-5) and stride 1 (layer 6) pooling, then signals tile completion.

---
 rtl/max_pool_ctrl_if.sv | 29 ++
 rtl/max_pool_ctrl.sv | 163 ++++++++++++++++
 tb/tb_max_pool_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_ctrl_if.sv
// Row stream bundle between the pooling lane array, the vertical max-pool
// controller and the downstream consumer.
interface max_pool_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_MODULES = 16
);
    localparam int ROW_BITS = DATA_WIDTH * 2 * NUM_MODULES;

    // Both streams use plain valid/ready: a beat transfers on a rising edge
    // where valid && ready; valid never waits on ready, and the sender holds
    // data stable while valid && !ready.
    logic                   row_valid;
    logic [ROW_BITS-1:0]    row_data;
    logic                   row_ready;
    logic                   pool_valid;
    logic [ROW_BITS-1:0]    pool_data;
    logic [NUM_MODULES-1:0] pool_mask;
    logic                   pool_ready;

    modport master (
        input  row_valid, row_data, pool_ready,
        output row_ready, pool_valid, pool_data, pool_mask
    );

    modport slave (
        output row_valid, row_data, pool_ready,
        input  row_ready, pool_valid, pool_data, pool_mask
    );
endinterface

// File: rtl/max_pool_ctrl.sv
// Vertical half of the 2x2 max-pool: pairs horizontally pooled rows through a
// one-row hold register and emits pooled rows with a lane-valid mask.
module max_pool_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_MODULES = 16,
    parameter int ROW_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stride2,
    input  logic [ROW_W-1:0] num_rows,
    max_pool_ctrl_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);
    localparam int LANE_W   = DATA_WIDTH * 2;
    localparam int ROW_BITS = LANE_W * NUM_MODULES;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PAIR  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_BITS-1:0]    hold_q, hold_d;
    logic [ROW_BITS-1:0]    out_data_q, out_data_d;
    logic [NUM_MODULES-1:0] out_mask_q, out_mask_d;
    logic                   out_full_q, out_full_d;
    logic [ROW_W-1:0]       rows_in_q, rows_in_d;
    logic [ROW_W-1:0]       num_rows_q, num_rows_d;
    logic                   stride2_q, stride2_d;

    logic                   in_phase, out_free, rows_left;
    logic                   accept, retire, need_flush;
    logic [ROW_BITS-1:0]    max_in, max_flush;
    logic [NUM_MODULES-1:0] mask_sel;

    function automatic logic [ROW_BITS-1:0] lane_max(input logic [ROW_BITS-1:0] a,
                                                     input logic [ROW_BITS-1:0] b);
        logic [ROW_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            if ($signed(a[i*LANE_W +: LANE_W]) >= $signed(b[i*LANE_W +: LANE_W]))
                r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W];
            else
                r[i*LANE_W +: LANE_W] = b[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    // Stride 2 keeps only the even lanes: odd lanes overlap their neighbour's window.
    always_comb begin
        mask_sel = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            mask_sel[i] = !stride2_q || ((i % 2) == 0);
        end
    end

    assign max_in     = lane_max(hold_q, bus.row_data);
    assign max_flush  = lane_max(hold_q, '0);

    assign in_phase   = (state_q == S_LOAD) || (state_q == S_PAIR);
    assign out_free   = !out_full_q || bus.pool_ready;
    assign rows_left  = rows_in_q < num_rows_q;
    assign accept     = bus.row_valid && bus.row_ready;
    assign retire     = out_full_q && bus.pool_ready;
    assign need_flush = !stride2_q || num_rows_q[0];

    assign bus.row_ready  = in_phase && out_free && rows_left;
    assign bus.pool_valid = out_full_q;
    assign bus.pool_data  = out_data_q;
    assign bus.pool_mask  = out_mask_q;
    assign busy           = (state_q != S_IDLE) && !done;
    assign state_dbg      = state_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;
        out_full_d = out_full_q && !retire;
        rows_in_d  = rows_in_q;
        num_rows_d = num_rows_q;
        stride2_d  = stride2_q;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stride2_d  = stride2;
                    num_rows_d = num_rows;
                    rows_in_d  = '0;
                    state_d    = (num_rows == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (!rows_left) begin
                    state_d = need_flush ? S_FLUSH : S_DONE;
                end else if (accept) begin
                    hold_d    = bus.row_data;
                    rows_in_d = rows_in_q + ROW_W'(1);
                    state_d   = S_PAIR;
                end
            end
            S_PAIR: begin
                if (!rows_left) begin
                    state_d = need_flush ? S_FLUSH : S_DONE;
                end else if (accept) begin
                    out_data_d = max_in;
                    out_mask_d = mask_sel;
                    out_full_d = 1'b1;
                    rows_in_d  = rows_in_q + ROW_W'(1);
                    // Stride 1 slides the window: the new row pairs with the next one.
                    if (stride2_q) state_d = S_LOAD;
                    else           hold_d  = bus.row_data;
                end
            end
            S_FLUSH: begin
                // The partner-less last row meets zero, like the array's right-edge pad.
                if (out_free) begin
                    out_data_d = max_flush;
                    out_mask_d = mask_sel;
                    out_full_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (!out_full_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
            out_full_q <= 1'b0;
            rows_in_q  <= '0;
            num_rows_q <= '0;
            stride2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
            out_full_q <= out_full_d;
            rows_in_q  <= rows_in_d;
            num_rows_q <= num_rows_d;
            stride2_q  <= stride2_d;
        end
    end
endmodule

// File: tb/tb_max_pool_ctrl.sv
// Directed bench for max_pool_ctrl: hand-computed pooled rows go into an
// expected queue that a negedge monitor drains on every output handshake.
module tb_max_pool_ctrl;
    localparam int DW    = 8;
    localparam int NM    = 16;
    localparam int ROW_W = 8;
    localparam int LW    = DW * 2;
    localparam int RW    = LW * NM;
    localparam logic [NM-1:0] MASK_S2 = 16'h5555;
    localparam logic [NM-1:0] MASK_S1 = 16'hFFFF;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stride2 = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             busy, done;
    logic [2:0]       state_dbg;
    int               cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_pool_ctrl_if #(.DATA_WIDTH(DW), .NUM_MODULES(NM)) bus ();

    max_pool_ctrl #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .ROW_W(ROW_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stride2   (stride2),
        .num_rows  (num_rows),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    logic [NM-1:0] mask_q[$];
    int            n_vec = 0;
    int            n_fail = 0;
    int            n_out = 0;
    int            last_out_cyc = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] rep(input int v);
        logic [RW-1:0] r;
        logic [LW-1:0] l;
        l = v[LW-1:0];
        for (int i = 0; i < NM; i++) r[i*LW +: LW] = l;
        return r;
    endfunction

    function automatic logic [RW-1:0] lane(input int j, input int v);
        logic [RW-1:0] r;
        logic [LW-1:0] l;
        l = v[LW-1:0];
        r = '0;
        r[j*LW +: LW] = l;
        return r;
    endfunction

    task automatic expect_out(input logic [RW-1:0] d, input logic [NM-1:0] m);
        exp_q.push_back(d);
        mask_q.push_back(m);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.pool_valid && bus.pool_ready) begin
            check("out_expected", RW'(exp_q.size() != 0), RW'(1));
            if (exp_q.size() != 0) begin
                check("pool_data", bus.pool_data, exp_q.pop_front());
                check("pool_mask", RW'(bus.pool_mask), RW'(mask_q.pop_front()));
            end
            n_out++;
            last_out_cyc = cyc;
        end
    end

    // ---------------- drivers ----------------
    task automatic start_tile(input logic s2, input int n);
        stride2  = s2;
        num_rows = n[ROW_W-1:0];
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic drive_row(input logic [RW-1:0] d);
        bus.row_valid = 1'b1;
        bus.row_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.row_ready) break;
        end
        check("row_accept", RW'(bus.row_ready), RW'(1));
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
    endtask

    task automatic wait_done(input bit chk_lat, output int lat);
        int k;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        lat = k;
        check("done_seen", RW'(done), RW'(1));
        if (chk_lat) check("done_latency", RW'(cyc - last_out_cyc), RW'(1));
        @(negedge clk);
        check("done_one_cycle", RW'(done), '0);
        check("busy_after_done", RW'(busy), '0);
        check("sb_drained", RW'(exp_q.size()), '0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_ready"}, RW'(bus.row_ready), '0);
        check({tag, "_pool_valid"}, RW'(bus.pool_valid), '0);
        check({tag, "_busy"}, RW'(busy), '0);
        check({tag, "_done"}, RW'(done), '0);
        check({tag, "_pool_data"}, bus.pool_data, '0);
        check({tag, "_pool_mask"}, RW'(bus.pool_mask), '0);
        check({tag, "_state"}, RW'(state_dbg), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int lat;
        int outs0;
        logic [RW-1:0] snap;

        bus.row_valid  = 1'b0;
        bus.row_data   = '0;
        bus.pool_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Stride 2, four rows, no backpressure
        expect_out(rep(7), MASK_S2);
        expect_out(rep(5), MASK_S2);
        outs0 = n_out;
        start_tile(1'b1, 4);
        drive_row(rep(3));
        drive_row(rep(7));
        drive_row(rep(-2));
        drive_row(rep(5));
        wait_done(1'b1, lat);
        check("s2_out_count", RW'(n_out - outs0), RW'(2));

        // Stride 1, three rows; a stray start mid-tile must be ignored
        expect_out(rep(-1), MASK_S1);
        expect_out(rep(-1), MASK_S1);
        expect_out(rep(0), MASK_S1);
        outs0 = n_out;
        start_tile(1'b0, 3);
        drive_row(rep(-4));
        start    = 1'b1;
        stride2  = 1'b1;
        num_rows = '0;
        drive_row(rep(-1));
        start    = 1'b0;
        drive_row(rep(-6));
        wait_done(1'b1, lat);
        check("s1_out_count", RW'(n_out - outs0), RW'(3));

        // Stride 2, odd row count: the last row is flushed against zero
        expect_out(lane(3, 10), MASK_S2);
        expect_out(rep(0), MASK_S2);
        outs0 = n_out;
        start_tile(1'b1, 3);
        drive_row(lane(3, 10));
        drive_row(lane(3, 2));
        drive_row(lane(3, -8));
        wait_done(1'b1, lat);
        check("odd_out_count", RW'(n_out - outs0), RW'(2));

        // Backpressure on the first output of a stride-2 tile
        expect_out(rep(7), MASK_S2);
        expect_out(rep(5), MASK_S2);
        outs0 = n_out;
        bus.pool_ready = 1'b0;
        start_tile(1'b1, 4);
        fork
            begin
                drive_row(rep(3));
                drive_row(rep(7));
                drive_row(rep(-2));
                drive_row(rep(5));
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (bus.pool_valid) break;
                end
                check("bp_valid_seen", RW'(bus.pool_valid), RW'(1));
                snap = bus.pool_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_data_stable", bus.pool_data, snap);
                    check("bp_row_ready_low", RW'(bus.row_ready), '0);
                end
                @(posedge clk); #1;
                bus.pool_ready = 1'b1;
            end
        join
        wait_done(1'b1, lat);
        check("bp_out_count", RW'(n_out - outs0), RW'(2));

        // Empty tile
        outs0 = n_out;
        start_tile(1'b1, 0);
        wait_done(1'b0, lat);
        check("zero_done_within_2", RW'(lat <= 2), RW'(1));
        check("zero_out_count", RW'(n_out - outs0), '0);

        // Reset after the first row of a four-row tile
        start_tile(1'b1, 4);
        drive_row(rep(9));
        rst = 1'b1;
        @(negedge clk);
        check("pre_reset_busy", RW'(busy), RW'(1));
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_done", RW'(done), '0);
        end
        @(posedge clk); #1;

        // Fresh two-row tile after the abort
        expect_out(rep(-3), MASK_S2);
        outs0 = n_out;
        start_tile(1'b1, 2);
        drive_row(rep(-3));
        drive_row(rep(-9));
        wait_done(1'b1, lat);
        check("post_rst_out_count", RW'(n_out - outs0), RW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
